// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: passive VGA raster checker. Measures hsync/vsync timing
// against the configured mode, locks onto a valid raster, counts frames and
// sums r+g+b over the active area of every completed frame.
module vga_timing_monitor #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned COLOR_W     = 4,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    input  logic               err_clr,
    output logic               locked,
    output logic               h_err,
    output logic               v_err,
    output logic [15:0]        frame_cnt,
    output logic [31:0]        frame_sum,
    output logic               frame_done
);
    localparam int unsigned H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
    localparam int unsigned V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;
    localparam int unsigned H_MAX   = 2 * H_TOTAL;
    localparam int unsigned V_MAX   = 2 * V_TOTAL;
    localparam int unsigned HW      = $clog2(H_MAX + 1);
    localparam int unsigned VW      = $clog2(V_MAX + 1);
    localparam int unsigned LW      = $clog2(LOCK_FRAMES + 1);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]    state, state_d;
    logic [LW-1:0] trk_cnt, trk_d;
    logic          hs_prev, vs_prev;
    logic [HW-1:0] h_cnt;
    logic          h_seen;
    logic [VW-1:0] v_cnt, vs_lines;
    logic          v_pend, v_anchor, vs_seen;
    logic [31:0]   acc;
    logic          frame_bad;

    logic          hs_act, vs_act, h_lead, h_trail, v_lead, v_trail;
    logic [HW-1:0] h_inc, h_pos;
    logic [VW-1:0] v_inc, v_pos, vs_inc;
    logic          h_tmo, h_err_now, v_rst, v_per_err, v_wid_err, v_err_now, err_now;
    logic          pix_act;
    logic [31:0]   pix_sum;

    // Edge detection, counter next values and timing error decode for the current tick.
    // A vsync edge coinciding with an hsync edge restarts the line count on that same line.
    always_comb begin
        hs_act    = (hsync == SYNC_POL);
        vs_act    = (vsync == SYNC_POL);
        h_lead    = hs_act & ~hs_prev;
        h_trail   = ~hs_act & hs_prev;
        v_lead    = vs_act & ~vs_prev;
        v_trail   = ~vs_act & vs_prev;

        h_inc     = (h_cnt == HW'(H_MAX)) ? h_cnt : HW'(h_cnt + 1'b1);
        h_pos     = h_lead ? '0 : h_inc;
        h_tmo     = ~h_lead & (h_cnt == HW'(H_MAX - 1));
        h_err_now = h_tmo
                  | (h_seen & h_lead  & (h_cnt != HW'(H_TOTAL - 1)))
                  | (h_seen & h_trail & (h_cnt != HW'(H_SYNC - 1)));

        v_rst     = h_lead & (v_pend | v_lead);
        v_inc     = (v_cnt == VW'(V_MAX)) ? v_cnt : VW'(v_cnt + 1'b1);
        v_pos     = v_rst ? '0 : (h_lead ? v_inc : v_cnt);
        vs_inc    = (vs_lines == VW'(V_MAX)) ? vs_lines : VW'(vs_lines + 1'b1);
        v_per_err = v_rst & v_anchor & (v_cnt != VW'(V_TOTAL - 1));
        v_wid_err = v_trail & vs_seen & (vs_lines != VW'(V_SYNC));
        v_err_now = v_per_err | v_wid_err;
        err_now   = h_err_now | v_err_now;

        pix_act   = (h_pos >= HW'(H_SYNC + H_BP)) & (h_pos < HW'(H_SYNC + H_BP + H_ACTIVE))
                  & (v_pos >= VW'(V_SYNC + V_BP)) & (v_pos < VW'(V_SYNC + V_BP + V_ACTIVE));
        pix_sum   = 32'(r) + 32'(g) + 32'(b);
    end

    // Lock state machine: next state and clean-frame count.
    always_comb begin
        state_d = state;
        trk_d   = trk_cnt;
        if (pix_en) begin
            if (h_tmo) begin
                state_d = SEARCH;
                trk_d   = '0;
            end else begin
                case (state)
                    SEARCH: begin
                        if (v_lead) begin
                            state_d = TRACK;
                            trk_d   = '0;
                        end
                    end
                    TRACK: begin
                        if (err_now) begin
                            trk_d = '0;
                        end else if (v_lead && !frame_bad) begin
                            if (trk_cnt == LW'(LOCK_FRAMES - 1)) begin
                                state_d = LOCKED;
                                trk_d   = '0;
                            end else begin
                                trk_d = LW'(trk_cnt + 1'b1);
                            end
                        end
                    end
                    LOCKED: begin
                        if (err_now) begin
                            state_d = TRACK;
                            trk_d   = '0;
                        end
                    end
                    default: begin
                        state_d = SEARCH;
                        trk_d   = '0;
                    end
                endcase
            end
        end
    end

    // State register and lock output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SEARCH;
            trk_cnt <= '0;
            locked  <= 1'b0;
        end else begin
            state   <= state_d;
            trk_cnt <= trk_d;
            locked  <= (state_d == LOCKED);
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_err <= 1'b0;
            v_err <= 1'b0;
        end else begin
            h_err <= (h_err & ~err_clr) | (pix_en & h_err_now);
            v_err <= (v_err & ~err_clr) | (pix_en & v_err_now);
        end
    end

    // Sync history, raster counters and per-frame checksum, advanced on pixel ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev    <= 1'b0;
            vs_prev    <= 1'b0;
            h_cnt      <= '0;
            h_seen     <= 1'b0;
            v_cnt      <= '0;
            v_pend     <= 1'b0;
            v_anchor   <= 1'b0;
            vs_seen    <= 1'b0;
            vs_lines   <= '0;
            acc        <= '0;
            frame_bad  <= 1'b0;
            frame_cnt  <= '0;
            frame_sum  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pix_en) begin
                hs_prev   <= hs_act;
                vs_prev   <= vs_act;
                h_cnt     <= h_pos;
                v_cnt     <= v_pos;
                h_seen    <= h_tmo ? 1'b0 : (h_seen | h_lead);
                v_anchor  <= h_tmo ? 1'b0 : (v_anchor | v_rst);
                vs_seen   <= h_tmo ? 1'b0 : (vs_seen | v_lead);
                if (h_tmo || h_lead) begin
                    v_pend <= v_lead & ~h_lead & ~h_tmo;
                end else if (v_lead) begin
                    v_pend <= 1'b1;
                end
                if (v_lead) begin
                    vs_lines <= h_lead ? VW'(1) : '0;
                end else if (vs_act && h_lead) begin
                    vs_lines <= vs_inc;
                end
                frame_bad <= v_lead ? 1'b0 : (frame_bad | err_now);
                if (v_lead) begin
                    acc <= pix_act ? pix_sum : '0;
                    if (state != SEARCH) begin
                        frame_sum  <= acc;
                        frame_done <= 1'b1;
                        if (state == LOCKED) begin
                            frame_cnt <= 16'(frame_cnt + 16'd1);
                        end
                    end
                end else if (pix_act) begin
                    acc <= acc + pix_sum;
                end
            end
        end
    end

endmodule
